// File: rtl/uart_tx_dev_if.sv
// uart_tx_dev_if: word-addressed register bus between a bridge and the UART transmitter.
// Latency: writes take effect on the clock edge that samples we; rdata is combinational.
// Backpressure: none; every access completes in one cycle.
interface uart_tx_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  // Bridge side drives the access, reads back data.
  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  // Peripheral side decodes the access and returns data.
  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter; even parity bit added when UART_TX_PARITY_EN is defined.
// Latency: BUSY/START on the DATA-write edge, uart_txd follows the state one cycle later; BUSY lasts 10*D (11*D) cycles.
// Backpressure: none on the bus; DATA writes while BUSY are dropped, software polls BUSY or waits for irq.
module uart_tx_dev #(
  parameter int unsigned DEFAULT_DIV = 2083
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_dev_if.slave bus,
  output logic         uart_txd,
  output logic         irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Shortest bit period the baud counter supports.
  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Frame state.
  state_t      state_q;
  logic [7:0]  data_q;      // last byte accepted; also the shift source during DATA
  logic [15:0] bit_div_q;   // divisor captured at frame start, clamped to MIN_DIV
  logic [15:0] baud_cnt_q;  // cycles elapsed within the current bit
  logic [2:0]  bit_idx_q;   // data bit currently on the line
  logic        busy_q;
  logic        done_q;
  logic        txd_q;

  // Software configuration.
  logic [15:0] div_q;
  logic        ien_q;

  // Decoded bus strobes.
  logic        wr_data;
  logic        wr_status;
  logic        wr_div;
  logic        wr_ctrl;

  // Frame control.
  logic [15:0] eff_div;
  logic        bit_end;
  logic        frame_start;
  logic        frame_end;
  logic        line_bit;

  // Upper write-data bits have no register behind them.
  logic        unused_wdata;
  assign unused_wdata = ^bus.wdata[31:16];

  assign wr_data   = bus.we && (bus.addr == ADDR_DATA);
  assign wr_status = bus.we && (bus.addr == ADDR_STATUS);
  assign wr_div    = bus.we && (bus.addr == ADDR_DIV);
  assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);

  // Divisors of 0 or 1 would make a bit shorter than the counter can express.
  assign eff_div = (div_q < MIN_DIV) ? MIN_DIV : div_q;

  // Last cycle of the current bit period.
  assign bit_end = (baud_cnt_q == (bit_div_q - 16'd1));

  // A DATA write is only honoured when the transmitter is fully idle; a write
  // landing on the edge BUSY clears still sees busy_q=1 and is dropped.
  assign frame_start = wr_data && (state_q == S_IDLE) && !busy_q;
  assign frame_end   = (state_q == S_STOP) && bit_end;

  // Line level owed to the current state; registered into txd_q so the pin
  // never sees a combinational path from the bus.
  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      S_IDLE:     line_bit = 1'b1;
      S_START:    line_bit = 1'b0;
      S_DATA:     line_bit = data_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY:   line_bit = ^data_q;
`endif
      S_STOP:     line_bit = 1'b1;
      default:    line_bit = 1'b1;
    endcase
  end

  // Software-owned DIVISOR and CTRL registers; DIVISOR may change mid-frame
  // because the frame runs from its own captured copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 16'(DEFAULT_DIV);
      ien_q <= 1'b0;
    end else begin
      if (wr_div) begin
        div_q <= bus.wdata[15:0];
      end
      if (wr_ctrl) begin
        ien_q <= bus.wdata[0];
      end
    end
  end

  // Transmit FSM with registered BUSY, DONE and line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= 8'h00;
      bit_div_q  <= 16'd0;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      txd_q <= line_bit;

      // Completion beats a simultaneous software clear.
      if (frame_end) begin
        done_q <= 1'b1;
      end else if (wr_status) begin
        done_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            data_q     <= bus.wdata[7:0];
            bit_div_q  <= eff_div;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            state_q    <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Register read mux; unused bits read as zero.
  always_comb begin
    bus.rdata = 32'h0000_0000;
    case (bus.addr)
      ADDR_DATA:   bus.rdata = {24'h00_0000, data_q};
      ADDR_STATUS: bus.rdata = {30'h0000_0000, done_q, busy_q};
      ADDR_DIV:    bus.rdata = {16'h0000, div_q};
      ADDR_CTRL:   bus.rdata = {31'h0000_0000, ien_q};
      default:     bus.rdata = 32'h0000_0000;
    endcase
  end

  assign uart_txd = txd_q;
  assign irq      = done_q & ien_q;

endmodule
